// File: rtl/gt_tx_pkg.sv
// Shared types and constants for the GT TX idle-inserter slice.
package gt_tx_pkg;

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      STARTUP = 2'd1,
      RUN     = 2'd2
   } state_t;

   localparam logic [1:0]  c_K_IDLE       = 2'b10;
   localparam logic [1:0]  c_K_DATA       = 2'b00;
   localparam logic [15:0] c_IDLE_DEFAULT = 16'hBC95;

endpackage

// File: rtl/gt_tx_skid_fifo.sv
// Two-entry payload FIFO with occupancy count and synchronous flush.
// A push while full or a pop while empty is ignored.
module gt_tx_skid_fifo (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        flush_i,
   input  logic        push_i,
   input  logic [15:0] data_i,
   input  logic        pop_i,
   output logic [15:0] data_o,
   output logic [1:0]  count_o
);

   logic [15:0] mem_q [2];
   logic        wr_ptr_q;
   logic        rd_ptr_q;
   logic [1:0]  count_q;
   logic        do_push;
   logic        do_pop;

   // Qualify requests against the current occupancy.
   always_comb begin
      do_pop  = pop_i && (count_q != 2'd0);
      do_push = push_i && (count_q != 2'd2);
   end

   // Storage, pointers and count; flush empties without touching storage.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (do_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/gt_tx_idle_inserter.sv
// TX framer for the 16-bit 8b/10b GT link: sends a startup IDLE burst, then
// payload words with a forced IDLE at slot 0 of every period and IDLE filler
// when no payload is buffered.
// Option macro TX_TIMESTAMP_EN: data slots carry a free-running 16-bit cycle
// counter instead of FIFO payload (payload input ignored, s_ready_o held 0).
module gt_tx_idle_inserter
   import gt_tx_pkg::*;
#(
   parameter logic [15:0] g_IDLE          = c_IDLE_DEFAULT,
   parameter int unsigned g_IDLE_PERIOD   = 193,
   parameter int unsigned g_STARTUP_IDLES = 64
) (
   input  logic        usrclk_i,
   input  logic        rst_n_i,
   input  logic        en_i,
   input  logic [15:0] s_data_i,
   input  logic        s_valid_i,
   output logic        s_ready_o,
   output logic [15:0] tx_data_o,
   output logic [1:0]  tx_k_o,
   output logic        link_up_o,
   output logic        underrun_o,
   output logic [31:0] data_cnt_o
);

   localparam int unsigned SLOT_W = $clog2(g_IDLE_PERIOD);
   localparam int unsigned SU_W   = (g_STARTUP_IDLES > 1) ? $clog2(g_STARTUP_IDLES) : 1;

   state_t            state_q;
   logic [SLOT_W-1:0] slot_q;
   logic [SU_W-1:0]   su_cnt_q;
   logic [15:0]       tx_data_q;
   logic [1:0]        tx_k_q;
   logic              link_up_q;
   logic              underrun_q;
   logic [31:0]       data_cnt_q;

   logic              data_slot;
   logic              word_avail;
   logic [15:0]       word;
   logic              su_last;
   logic              slot_last;

   assign data_slot = en_i && (state_q == RUN) && (slot_q != '0);
   assign su_last   = (su_cnt_q == SU_W'(g_STARTUP_IDLES - 1));
   assign slot_last = (slot_q == SLOT_W'(g_IDLE_PERIOD - 1));

`ifdef TX_TIMESTAMP_EN
   logic [15:0] ts_q;
   logic        ts_unused;

   assign ts_unused  = ^{s_data_i, s_valid_i};
   assign s_ready_o  = 1'b0;
   assign word_avail = 1'b1;
   assign word       = ts_q;

   // Free-running cycle counter used as the data-slot payload.
   always_ff @(posedge usrclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ts_q <= '0;
      end else begin
         ts_q <= ts_q + 16'd1;
      end
   end
`else
   logic [1:0]  fifo_cnt;
   logic [15:0] fifo_head;
   logic        fifo_push;
   logic        fifo_pop;

   assign s_ready_o  = (fifo_cnt != 2'd2) && (state_q != OFF);
   assign fifo_push  = s_valid_i && s_ready_o;
   assign word_avail = (fifo_cnt != 2'd0);
   assign fifo_pop   = data_slot && word_avail;
   assign word       = fifo_head;

   // Flushing on en_i low drops buffered words in the same edge that enters OFF.
   gt_tx_skid_fifo u_fifo (
      .clk_i   (usrclk_i),
      .rst_n_i (rst_n_i),
      .flush_i (~en_i),
      .push_i  (fifo_push),
      .data_i  (s_data_i),
      .pop_i   (fifo_pop),
      .data_o  (fifo_head),
      .count_o (fifo_cnt)
   );
`endif

   // Link FSM with slot/startup counters and registered TX outputs.
   always_ff @(posedge usrclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= OFF;
         slot_q     <= '0;
         su_cnt_q   <= '0;
         tx_data_q  <= g_IDLE;
         tx_k_q     <= c_K_IDLE;
         link_up_q  <= 1'b0;
         underrun_q <= 1'b0;
         data_cnt_q <= '0;
      end else begin
         tx_data_q  <= g_IDLE;
         tx_k_q     <= c_K_IDLE;
         underrun_q <= 1'b0;
         if (!en_i) begin
            state_q   <= OFF;
            slot_q    <= '0;
            su_cnt_q  <= '0;
            link_up_q <= 1'b0;
         end else begin
            case (state_q)
               OFF: begin
                  state_q  <= STARTUP;
                  su_cnt_q <= '0;
               end
               STARTUP: begin
                  if (su_last) begin
                     state_q   <= RUN;
                     slot_q    <= '0;
                     link_up_q <= 1'b1;
                  end else begin
                     su_cnt_q <= su_cnt_q + 1'b1;
                  end
               end
               RUN: begin
                  slot_q <= slot_last ? '0 : slot_q + 1'b1;
                  if (data_slot) begin
                     if (word_avail) begin
                        tx_data_q  <= word;
                        tx_k_q     <= c_K_DATA;
                        data_cnt_q <= data_cnt_q + 32'd1;
                     end else begin
                        underrun_q <= 1'b1;
                     end
                  end
               end
               default: begin
                  state_q <= OFF;
               end
            endcase
         end
      end
   end

   assign tx_data_o  = tx_data_q;
   assign tx_k_o     = tx_k_q;
   assign link_up_o  = link_up_q;
   assign underrun_o = underrun_q;
   assign data_cnt_o = data_cnt_q;

endmodule

// File: tb/tb_gt_tx_idle_inserter.sv
// Self-checking bench for gt_tx_idle_inserter (period 5, 4 startup IDLEs).
// A link-level model (mode, startup IDLE count, cycles-in-RUN, word queue)
// predicts every registered output each cycle; directed sections pin literals.
module tb_gt_tx_idle_inserter;

   localparam int unsigned P  = 5;
   localparam int unsigned SU = 4;
   localparam logic [15:0] IDLE = 16'hBC95;

   localparam int M_OFF = 0;
   localparam int M_SU  = 1;
   localparam int M_RUN = 2;

   logic        usrclk_i = 1'b0;
   logic        rst_n_i;
   logic        en_i;
   logic [15:0] s_data_i;
   logic        s_valid_i;
   logic        s_ready_o;
   logic [15:0] tx_data_o;
   logic [1:0]  tx_k_o;
   logic        link_up_o;
   logic        underrun_o;
   logic [31:0] data_cnt_o;

   int errors = 0;
   int checks = 0;
   bit cmp_en = 1'b0;

   gt_tx_idle_inserter #(
      .g_IDLE          (IDLE),
      .g_IDLE_PERIOD   (P),
      .g_STARTUP_IDLES (SU)
   ) dut (
      .usrclk_i   (usrclk_i),
      .rst_n_i    (rst_n_i),
      .en_i       (en_i),
      .s_data_i   (s_data_i),
      .s_valid_i  (s_valid_i),
      .s_ready_o  (s_ready_o),
      .tx_data_o  (tx_data_o),
      .tx_k_o     (tx_k_o),
      .link_up_o  (link_up_o),
      .underrun_o (underrun_o),
      .data_cnt_o (data_cnt_o)
   );

   always #5 usrclk_i = ~usrclk_i;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int          m_mode;
   int          m_sent;
   int          m_run;
   logic [15:0] m_q[$];
   logic [15:0] m_ts;
   logic [15:0] exp_data;
   logic [1:0]  exp_k;
   logic        exp_link;
   logic        exp_urun;
   logic [31:0] exp_cnt;

   function automatic bit m_ready();
`ifdef TX_TIMESTAMP_EN
      return 1'b0;
`else
      return (m_q.size() < 2) && (m_mode != M_OFF);
`endif
   endfunction

   initial begin : model
      bit push;
      m_mode = M_OFF; m_sent = 0; m_run = 0; m_ts = '0;
      exp_data = IDLE; exp_k = 2'b10; exp_link = 1'b0; exp_urun = 1'b0; exp_cnt = '0;
      forever begin
         @(posedge usrclk_i or negedge rst_n_i);
         if (!rst_n_i) begin
            m_mode = M_OFF; m_q.delete(); m_ts = '0;
            exp_data = IDLE; exp_k = 2'b10; exp_link = 1'b0; exp_urun = 1'b0; exp_cnt = '0;
         end else begin
            push = s_valid_i && m_ready();
            exp_data = IDLE; exp_k = 2'b10; exp_urun = 1'b0;
            if (!en_i) begin
               m_mode = M_OFF; m_q.delete(); exp_link = 1'b0;
            end else begin
               if (m_mode == M_OFF) begin
                  m_mode = M_SU; m_sent = 0;
               end else if (m_mode == M_SU) begin
                  m_sent++;
                  if (m_sent == SU) begin
                     m_mode = M_RUN; m_run = 0; exp_link = 1'b1;
                  end
               end else begin
                  if ((m_run % P) != 0) begin
`ifdef TX_TIMESTAMP_EN
                     exp_data = m_ts; exp_k = 2'b00; exp_cnt++;
`else
                     if (m_q.size() > 0) begin
                        exp_data = m_q.pop_front(); exp_k = 2'b00; exp_cnt++;
                     end else begin
                        exp_urun = 1'b1;
                     end
`endif
                  end
                  m_run++;
               end
               if (push) m_q.push_back(s_data_i);
            end
            m_ts++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin : compare
      forever begin
         @(negedge usrclk_i);
         if (cmp_en) begin
            chk("tx_data", {16'h0, tx_data_o}, {16'h0, exp_data});
            chk("tx_k", {30'h0, tx_k_o}, {30'h0, exp_k});
            chk("link_up", {31'h0, link_up_o}, {31'h0, exp_link});
            chk("underrun", {31'h0, underrun_o}, {31'h0, exp_urun});
            chk("data_cnt", data_cnt_o, exp_cnt);
            chk("s_ready", {31'h0, s_ready_o}, {31'h0, m_ready()});
         end
      end
   end

   // One clock: inputs change 1 time unit after the edge; the payload source
   // advances to the next value whenever a word was accepted.
   task automatic cyc();
      bit acc;
      acc = s_valid_i && s_ready_o;
      @(posedge usrclk_i);
      #1;
      if (acc) s_data_i = s_data_i + 16'd1;
   endtask

   task automatic wait_link(output int n);
      n = 0;
      while (!link_up_o && n < 40) begin
         cyc();
         n++;
      end
   endtask

   // ---------------- stimulus and directed checks ----------------
   initial begin : stim
      int          n;
      int          cnt_a;
      int          cnt_b;
      logic [15:0] exp_seq [10];
      logic [15:0] nxt;
      rst_n_i = 1'b0; en_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
      repeat (3) @(posedge usrclk_i);
      #1 rst_n_i = 1'b1;
      cmp_en = 1'b1;

      // reset values
      chk("rst_tx_data", {16'h0, tx_data_o}, 32'h0000BC95);
      chk("rst_tx_k", {30'h0, tx_k_o}, 32'h2);
      chk("rst_ready", {31'h0, s_ready_o}, 32'h0);
      chk("rst_link", {31'h0, link_up_o}, 32'h0);
      chk("rst_cnt", data_cnt_o, 32'h0);

      // link disabled: IDLE-only for 100 cycles
      cnt_a = 0;
      for (int i = 0; i < 100; i++) begin
         cyc();
         if (tx_data_o == 16'hBC95 && tx_k_o == 2'b10 && !s_ready_o && !link_up_o) cnt_a++;
      end
      chk("off_idle_cycles", cnt_a, 100);

      // enable: one edge to leave OFF, then 4 startup IDLEs; link_up with the 4th
      s_data_i = 16'd1; s_valid_i = 1'b1; en_i = 1'b1;
      wait_link(n);
      chk("startup_len", n, 5);

`ifndef TX_TIMESTAMP_EN
      // continuous payload: slot 0 IDLE then 4 data words per period
      exp_seq = '{IDLE, 16'd1, 16'd2, 16'd3, 16'd4, IDLE, 16'd5, 16'd6, 16'd7, 16'd8};
      for (int i = 0; i < 10; i++) begin
         cyc();
         chk("seq_data", {16'h0, tx_data_o}, {16'h0, exp_seq[i]});
         chk("seq_k", {30'h0, tx_k_o}, (i == 0 || i == 5) ? 32'h2 : 32'h0);
      end
      chk("cnt_after_8", data_cnt_o, 32'd8);

      // starve the link: two full periods of IDLE with 8 underrun pulses
      s_valid_i = 1'b0;
      repeat (3) cyc();
      cnt_a = 0; cnt_b = 0;
      for (int i = 0; i < 2 * P; i++) begin
         cyc();
         if (underrun_o) cnt_a++;
         if (tx_k_o == 2'b10 && tx_data_o == IDLE) cnt_b++;
      end
      chk("underrun_pulses", cnt_a, 8);
      chk("starved_idles", cnt_b, 10);

      // drop enable mid-burst in RUN
      s_valid_i = 1'b1;
      repeat (7) cyc();
      en_i = 1'b0;
      cyc();
      chk("drop_ready", {31'h0, s_ready_o}, 32'h0);
      chk("drop_link", {31'h0, link_up_o}, 32'h0);
      cyc();

      // fill the FIFO during STARTUP, then drop enable with 2 words held
      en_i = 1'b1;
      repeat (3) cyc();
      chk("full_ready", {31'h0, s_ready_o}, 32'h0);
      en_i = 1'b0;
      cyc();
      chk("flush_tx", {14'h0, tx_k_o, tx_data_o}, 32'h0002BC95);
      chk("flush_ready", {31'h0, s_ready_o}, 32'h0);
      s_valid_i = 1'b0;
      cyc();
      en_i = 1'b1;
      cyc();
      chk("restart_link", {31'h0, link_up_o}, 32'h0);
      chk("restart_ready", {31'h0, s_ready_o}, 32'h1);
      wait_link(n);
      chk("restart_startup", n, 4);
      cnt_a = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (tx_k_o == 2'b00) cnt_a++;
      end
      chk("flushed_words", cnt_a, 0);
`endif

      // asynchronous reset mid-burst
      s_valid_i = 1'b1;
      repeat (12) cyc();
      rst_n_i = 1'b0;
      #1;
      chk("arst_tx", {14'h0, tx_k_o, tx_data_o}, 32'h0002BC95);
      chk("arst_ready", {31'h0, s_ready_o}, 32'h0);
      chk("arst_link", {31'h0, link_up_o}, 32'h0);
      chk("arst_urun", {31'h0, underrun_o}, 32'h0);
      chk("arst_cnt", data_cnt_o, 32'h0);
      @(posedge usrclk_i);
      #1;
      cyc();
      rst_n_i = 1'b1;

`ifndef TX_TIMESTAMP_EN
      // random valid, 10000 words: received stream must be consecutive
      nxt = s_data_i;
      cnt_a = 0; n = 0;
      while (cnt_a < 10000 && n < 60000) begin
         s_valid_i = (($urandom % 4) != 0);
         cyc();
         n++;
         if (tx_k_o == 2'b00) begin
            chk("rand_order", {16'h0, tx_data_o}, {16'h0, nxt});
            nxt = nxt + 16'd1;
            cnt_a++;
         end
      end
      chk("rand_words", cnt_a, 10000);
`else
      // timestamp slots step by 1 per cycle, by 2 across a forced IDLE
      wait_link(n);
      cnt_b = -1; cnt_a = 0;
      for (int i = 0; i < 40; i++) begin
         cyc();
         if (tx_k_o == 2'b00) begin
            if (cnt_b >= 0) chk("ts_step", {16'h0, tx_data_o - nxt}, cnt_a + 1);
            nxt = tx_data_o; cnt_b = 1; cnt_a = 0;
         end else begin
            cnt_a++;
         end
      end
`endif

      s_valid_i = 1'b0;
      repeat (3) cyc();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
